// File: rtl/seg_pkg.sv
// Shared constants for the key debouncer: counter width,
// default debounce length and the per-channel FSM encoding.
package seg_pkg;

    localparam int CNT_W            = 21;
    localparam int DEBOUNCE_DEFAULT = 1250000;

    localparam logic [1:0] ST_UP        = 2'd0;
    localparam logic [1:0] ST_WAIT_DOWN = 2'd1;
    localparam logic [1:0] ST_DOWN      = 2'd2;
    localparam logic [1:0] ST_WAIT_UP   = 2'd3;

    typedef enum logic [1:0] {
        S_UP        = ST_UP,
        S_WAIT_DOWN = ST_WAIT_DOWN,
        S_DOWN      = ST_DOWN,
        S_WAIT_UP   = ST_WAIT_UP
    } state_t;

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: 2-flop synchronizer on the inverted key,
// then a stable-count FSM producing level, press and release.
module debounce_chan
    import seg_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic CLOCK_125_p,
    input  logic reset,
    input  logic i_key_n,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_level_nxt
);

    localparam logic [CNT_W-1:0] LP_LIMIT = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] LP_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] LP_ZERO  = '0;

    logic             r_sync1;
    logic             r_sync2;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             w_s;
    logic             w_at_limit;

    assign w_s        = r_sync2;
    assign w_at_limit = (r_cnt == LP_LIMIT);

    // Bring the async active-low key into the clock domain as active-high
    always_ff @(posedge CLOCK_125_p) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= ~i_key_n;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce FSM; the counter stops at the limit because that compare exits the wait state
    always_ff @(posedge CLOCK_125_p) begin
        if (reset) begin
            r_state   <= S_UP;
            r_cnt     <= LP_ZERO;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            unique case (r_state)
                S_UP: begin
                    if (w_s) begin
                        r_state <= S_WAIT_DOWN;
                        r_cnt   <= LP_ONE;
                    end
                end
                S_WAIT_DOWN: begin
                    if (!w_s) begin
                        r_state <= S_UP;
                        r_cnt   <= LP_ZERO;
                    end else if (w_at_limit) begin
                        r_state <= S_DOWN;
                        r_cnt   <= LP_ZERO;
                        r_level <= 1'b1;
                        r_press <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + LP_ONE;
                    end
                end
                S_DOWN: begin
                    if (!w_s) begin
                        r_state <= S_WAIT_UP;
                        r_cnt   <= LP_ONE;
                    end
                end
                S_WAIT_UP: begin
                    if (w_s) begin
                        r_state <= S_DOWN;
                        r_cnt   <= LP_ZERO;
                    end else if (w_at_limit) begin
                        r_state   <= S_UP;
                        r_cnt     <= LP_ZERO;
                        r_level   <= 1'b0;
                        r_release <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + LP_ONE;
                    end
                end
                default: begin
                    r_state <= S_UP;
                    r_cnt   <= LP_ZERO;
                    r_level <= 1'b0;
                end
            endcase
        end
    end

    // Next-cycle level, so the parent can register key_any in step with key_level
    always_comb begin
        o_level_nxt = 1'b0;
        if (!reset) begin
            unique case (r_state)
                S_UP:        o_level_nxt = 1'b0;
                S_WAIT_DOWN: o_level_nxt = w_s && w_at_limit;
                S_DOWN:      o_level_nxt = 1'b1;
                S_WAIT_UP:   o_level_nxt = w_s || !w_at_limit;
                default:     o_level_nxt = 1'b0;
            endcase
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/key_debounce.sv
// Multi-channel push-button debouncer: one independent channel
// per key plus a registered any-key-pressed flag.
module key_debounce
    import seg_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int NUM_KEYS        = 4
) (
    input  logic                CLOCK_125_p,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] KEY,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                key_any
);

    logic [NUM_KEYS-1:0] w_level_nxt;
    logic                r_any;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
        debounce_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .CLOCK_125_p (CLOCK_125_p),
            .reset       (reset),
            .i_key_n     (KEY[g]),
            .o_level     (key_level[g]),
            .o_press     (key_press[g]),
            .o_release   (key_release[g]),
            .o_level_nxt (w_level_nxt[g])
        );
    end

    // Register the OR of next levels so key_any tracks key_level edge for edge
    always_ff @(posedge CLOCK_125_p) begin
        if (reset) begin
            r_any <= 1'b0;
        end else begin
            r_any <= |w_level_nxt;
        end
    end

    assign key_any = r_any;

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce with DEBOUNCE_CYCLES=4:
// stimulus queues expected pulses, a monitor pops and compares them.
module tb_key_debounce;

    localparam int D  = 4;
    localparam int NK = 4;
    localparam int LAT = D + 3;

    logic          clk;
    logic          reset;
    logic [NK-1:0] KEY;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic          key_any;

    typedef struct {
        int cyc;
        int p;
        int r;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    key_debounce #(
        .DEBOUNCE_CYCLES(D),
        .NUM_KEYS(NK)
    ) dut (
        .CLOCK_125_p (clk),
        .reset       (reset),
        .KEY         (KEY),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_any     (key_any)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    // Count rising edges so far
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_pulse(input int at, input int p, input int r);
        exp_t e;
        e.cyc = at;
        e.p   = p;
        e.r   = r;
        sbq.push_back(e);
    endtask

    // Monitor: any pulse must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if ((key_press | key_release) != '0) begin
            chk("no_both", int'(key_press & key_release), 0);
            chk("lvl_with_press", int'(key_level & key_press),
                int'(key_press));
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: press=%b release=%b cyc %0d",
                         key_press, key_release, cyc);
            end else begin
                e = sbq.pop_front();
                chk("pulse_cyc", cyc, e.cyc);
                chk("press", int'(key_press), e.p);
                chk("release", int'(key_release), e.r);
            end
        end
    end

    initial begin
        reset = 1'b1;
        KEY   = 4'b1111;
        step(3);
        chk("rst_level", int'(key_level), 0);
        chk("rst_press", int'(key_press), 0);
        chk("rst_release", int'(key_release), 0);
        chk("rst_any", int'(key_any), 0);

        // Clean press on key 0, held long: exactly one pulse
        reset = 1'b0;
        KEY   = 4'b1110;
        expect_pulse(cyc + LAT, 4'b0001, 0);
        step(20);
        chk("press0_level", int'(key_level), 4'b0001);
        chk("press0_any", int'(key_any), 1);

        // Release key 0
        KEY = 4'b1111;
        expect_pulse(cyc + LAT, 0, 4'b0001);
        step(10);
        chk("rel0_level", int'(key_level), 0);
        chk("rel0_any", int'(key_any), 0);

        // Bounce on key 1: low 2, high 1, low held
        KEY = 4'b1101;
        step(2);
        KEY = 4'b1111;
        step(1);
        KEY = 4'b1101;
        expect_pulse(cyc + LAT, 4'b0010, 0);
        step(12);
        chk("bounce_level", int'(key_level), 4'b0010);
        KEY = 4'b1111;
        expect_pulse(cyc + LAT, 0, 4'b0010);
        step(10);
        chk("bounce_rel_level", int'(key_level), 0);

        // Simultaneous press on keys 1 and 3
        KEY = 4'b0101;
        expect_pulse(cyc + LAT, 4'b1010, 0);
        step(10);
        chk("sim_level", int'(key_level), 4'b1010);
        chk("sim_any", int'(key_any), 1);
        KEY = 4'b1111;
        expect_pulse(cyc + LAT, 0, 4'b1010);
        step(10);
        chk("sim_rel_any", int'(key_any), 0);

        // Reset mid-debounce on key 2, sampled at the 5th edge
        KEY = 4'b1011;
        step(4);
        reset = 1'b1;
        step(1);
        chk("mid_rst_level", int'(key_level), 0);
        chk("mid_rst_press", int'(key_press), 0);
        chk("mid_rst_release", int'(key_release), 0);
        chk("mid_rst_any", int'(key_any), 0);
        reset = 1'b0;
        expect_pulse(cyc + LAT, 4'b0100, 0);
        step(10);
        chk("after_rst_level", int'(key_level), 4'b0100);

        // Reset while pressed: no release, key still low -> new press
        reset = 1'b1;
        step(1);
        chk("prs_rst_level", int'(key_level), 0);
        chk("prs_rst_any", int'(key_any), 0);
        reset = 1'b0;
        expect_pulse(cyc + LAT, 4'b0100, 0);
        step(10);
        chk("repress_level", int'(key_level), 4'b0100);
        KEY = 4'b1111;
        expect_pulse(cyc + LAT, 0, 4'b0100);
        step(10);

        // One-cycle glitch on key 3
        KEY = 4'b0111;
        step(1);
        KEY = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("glitch_level", int'(key_level), 0);
        end

        step(5);
        chk("sb_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1250000, SHALL set the stable-sample count needed to accept a key change (10 ms at 125 MHz); legal range 1..2^21-1.
REQ-002 Parameter NUM_KEYS, default 4, SHALL set the channel count.
REQ-003 CLOCK_125_p  input  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 KEY  input  NUM_KEYS  raw asynchronous push-buttons, active-low (0 = pressed).
REQ-006 key_level  output  NUM_KEYS  debounced state, active-high (1 = pressed).
REQ-007 key_press  output  NUM_KEYS  one-cycle pulse on an accepted press; feeds the display load enables.
REQ-008 key_release  output  NUM_KEYS  one-cycle pulse on an accepted release.
REQ-009 key_any  output  1  OR of key_level.

Function
REQ-010 Each channel SHALL pass its KEY bit, inverted, through a 2-flop synchronizer; the second flop output is the sample s.
REQ-011 Each channel SHALL run an independent FSM with states UP, WAIT_DOWN, DOWN and WAIT_UP, plus a 21-bit counter cnt.
REQ-012 UP: s=1 -> WAIT_DOWN with cnt<=1; otherwise stay in UP.
REQ-013 WAIT_DOWN: s=0 -> UP with cnt<=0 and no pulse (bounce rejected); s=1 and cnt==DEBOUNCE_CYCLES -> DOWN, with key_press=1 for that one cycle; otherwise cnt<=cnt+1.
REQ-014 DOWN: s=0 -> WAIT_UP with cnt<=1; otherwise stay in DOWN.
REQ-015 WAIT_UP: s=1 -> DOWN with cnt<=0 and no pulse; s=0 and cnt==DEBOUNCE_CYCLES -> UP, with key_release=1 for one cycle; otherwise cnt<=cnt+1.
REQ-016 key_level SHALL be 1 exactly in states DOWN and WAIT_UP.
REQ-017 All outputs SHALL be registered. key_press and key_level SHALL rise on the same edge.
REQ-018 Latency: with KEY[i] low from before edge 1 and held, key_press[i] SHALL be high for exactly the cycle following edge DEBOUNCE_CYCLES+3; release latency is symmetric.
REQ-019 cnt SHALL never wrap: it saturates at DEBOUNCE_CYCLES, and the transition out of the WAIT state occurs on that compare.
REQ-020 key_press and key_release SHALL never both be 1 on one channel in the same cycle; at most one pulse is issued per accepted transition.
REQ-021 Simultaneous activity on several channels SHALL be handled independently, with no arbitration, so several key_press bits may assert together.
REQ-022 A key held indefinitely SHALL produce exactly one key_press and no repeat.

Reset
REQ-023 While reset=1 at a clock edge, the synchronizer flops SHALL clear to 0 (not pressed), all FSMs SHALL go to UP, cnt SHALL go to 0, and key_level, key_press, key_release and key_any SHALL go to 0.
REQ-024 Reset asserted mid-debounce or mid-press SHALL abort the operation with no pulse emitted.
REQ-025 A key held through reset deassertion SHALL be treated as a new press, producing key_press DEBOUNCE_CYCLES+3 edges after reset falls.

Structure
REQ-026 The FSM state encoding (2-bit localparams) and the DEBOUNCE_CYCLES default SHALL reside in the shared package seg_pkg.
REQ-027 The single channel (synchronizer, FSM and counter) SHALL be sub-module debounce_chan, instantiated NUM_KEYS times by key_debounce, which also derives key_any.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-028 Clean press: KEY=4'b1110 held from edge 1 -> key_press=4'b0001 for one cycle after edge 7, key_level[0]=1 thereafter, and no further pulses.
REQ-029 Bounce: KEY[1] low 2 cycles, high 1, low held -> no key_press during the bounce; a single key_press[1] 7 edges after the final fall.
REQ-030 Release: from a debounced press, KEY=4'b1111 held -> key_release=4'b0001 for one cycle 7 edges later, key_level=0 and key_any=0.
REQ-031 Simultaneous: KEY=4'b0101 applied on one edge -> key_press=4'b1010 in the same single cycle.
REQ-032 Reset mid-debounce: KEY[2] low, reset pulsed at edge 5 -> no pulse and all outputs 0 on the edge reset is sampled; key_press[2] 7 edges after reset drops while KEY[2] stays low.
REQ-033 Glitch reject: a 1-cycle low pulse on KEY[3] -> no key_press and no key_level change.
